// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, TX/RX FSM states and parity helpers.
// Imported by the core and its interface users.
package uart_pkg;

    localparam int MAX_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1
    } rx_state_t;

    // Parity bit to transmit for data; mode 11 behaves as none.
    function automatic logic parity_bit(
        input logic [MAX_BITS-1:0] data,
        input logic [1:0]          mode
    );
        case (mode)
            PAR_EVEN: parity_bit = ^data;
            PAR_ODD:  parity_bit = ~^data;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

    function automatic logic par_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Bus-side handshake bundle of the UART core: TX request channel,
// RX FIFO head channel and status. master = bus wrapper, slave = core.
interface uart_core_param_if #(
    parameter int DATA_BITS = 8,
    parameter int LW        = 4
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_data_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_data_valid;
    logic                 rx_ready;
    logic                 rx_parity_error;
    logic                 rx_frame_error;
    logic                 rx_overrun;
    logic                 rx_busy;
    logic [LW-1:0]        rx_level;

    modport master (
        output tx_data, tx_data_valid, rx_ready,
        input  tx_ready, tx_busy, rx_data, rx_data_valid,
        input  rx_parity_error, rx_frame_error, rx_overrun,
        input  rx_busy, rx_level
    );

    modport slave (
        input  tx_data, tx_data_valid, rx_ready,
        output tx_ready, tx_busy, rx_data, rx_data_valid,
        output rx_parity_error, rx_frame_error, rx_overrun,
        output rx_busy, rx_level
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk, rst (sync, active high), push/din, pop/dout, full, empty, level.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_pop;
    logic             do_push;

    assign level = wp - rp;
    assign full  = (level == FULL_LVL);
    assign empty = (wp == rp);

    // Pop is served first, so a full FIFO still takes a same-cycle push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty head reads as zero so outputs are clean after reset.
    assign dout = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART core: oversample tick, TX FSM, RX FSM, RX FIFO.
// Ports: clk, rst, baud_div, parity_mode, two_stop, sin, sout, io (slave).
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 sin,
    output logic                 sout,
    uart_core_param_if.slave     io
);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int LW  = $clog2(RX_FIFO_DEPTH) + 1;
    localparam int FW  = DATA_BITS + 2;

    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] SMP_LO   = OSW'(OVERSAMPLE/2 - 2);
    localparam logic [OSW-1:0] SMP_MID  = OSW'(OVERSAMPLE/2 - 1);
    localparam logic [OSW-1:0] SMP_HI   = OSW'(OVERSAMPLE/2);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    // ---------------- tick generator ----------------
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 tick;

    // div_q only reloads at wrap, so a new divisor starts on a clean period.
    assign tick = (div_cnt >= div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            div_q   <= baud_div;
        end else if (tick) begin
            div_cnt <= '0;
            div_q   <= baud_div;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // ---------------- TX ----------------
    tx_state_t            tx_st;
    logic                 tx_ready_q;
    logic                 tx_busy_q;
    logic                 tx_run;
    logic                 tx_two;
    logic                 tx_pen;
    logic                 tx_par;
    logic [DATA_BITS-1:0] tx_sh;
    logic [OSW-1:0]       tx_tcnt;
    logic [BW-1:0]        tx_bit;
    logic                 tx_end;
    logic [MAX_BITS-1:0]  tx_ext;

    always_comb begin
        tx_ext = '0;
        tx_ext[DATA_BITS-1:0] = io.tx_data;
    end

    assign tx_end = tick && tx_run && (tx_tcnt == OS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st      <= TX_IDLE;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            sout       <= 1'b1;
            tx_run     <= 1'b0;
            tx_two     <= 1'b0;
            tx_pen     <= 1'b0;
            tx_par     <= 1'b0;
            tx_sh      <= '0;
            tx_tcnt    <= '0;
            tx_bit     <= '0;
        end else begin
            if (tick && tx_run)
                tx_tcnt <= (tx_tcnt == OS_LAST) ? '0 : tx_tcnt + OSW'(1);
            unique case (tx_st)
                TX_IDLE: begin
                    if (io.tx_data_valid) begin
                        tx_sh      <= io.tx_data;
                        tx_pen     <= par_en(parity_mode);
                        tx_par     <= parity_bit(tx_ext, parity_mode);
                        tx_two     <= two_stop;
                        tx_run     <= 1'b0;
                        tx_st      <= TX_START;
                        tx_ready_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                    end
                end
                TX_START: begin
                    // Hold the line idle until the first tick aligns the frame.
                    if (!tx_run) begin
                        if (tick) begin
                            tx_run  <= 1'b1;
                            tx_tcnt <= '0;
                            sout    <= 1'b0;
                        end
                    end else if (tx_end) begin
                        tx_st  <= TX_DATA;
                        tx_bit <= '0;
                        sout   <= tx_sh[0];
                    end
                end
                TX_DATA: begin
                    if (tx_end) begin
                        if (tx_bit == BIT_LAST) begin
                            tx_st <= tx_pen ? TX_PARITY : TX_STOP1;
                            sout  <= tx_pen ? tx_par : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + BW'(1);
                            tx_sh  <= tx_sh >> 1;
                            sout   <= tx_sh[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_end) begin
                        tx_st <= TX_STOP1;
                        sout  <= 1'b1;
                    end
                end
                TX_STOP1, TX_STOP2: begin
                    if (tx_end) begin
                        if (tx_st == TX_STOP1 && tx_two) begin
                            tx_st <= TX_STOP2;
                        end else begin
                            tx_st      <= TX_IDLE;
                            tx_run     <= 1'b0;
                            tx_busy_q  <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    assign io.tx_ready = tx_ready_q;
    assign io.tx_busy  = tx_busy_q;

    // ---------------- RX ----------------
    logic s1;
    logic s2;
    logic s_prev;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= sin;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign fall = s_prev & ~s2;

    rx_state_t            rx_st;
    logic [OSW-1:0]       rx_scnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic [1:0]           rx_mode;
    logic                 v0;
    logic                 v1;
    logic                 rx_perr;
    logic                 rx_busy_q;
    logic                 rx_push;
    logic [FW-1:0]        rx_push_d;
    logic                 maj;
    logic                 smp_hi;
    logic                 bit_end;
    logic [MAX_BITS-1:0]  rx_ext;

    always_comb begin
        rx_ext = '0;
        rx_ext[DATA_BITS-1:0] = rx_sh;
    end

    // Third sample is the live synced bit; earlier two are held in v0/v1.
    assign maj     = (v0 & v1) | (v0 & s2) | (v1 & s2);
    assign smp_hi  = tick && (rx_scnt == SMP_HI);
    assign bit_end = tick && (rx_scnt == OS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st     <= RX_IDLE;
            rx_scnt   <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_mode   <= 2'b00;
            v0        <= 1'b1;
            v1        <= 1'b1;
            rx_perr   <= 1'b0;
            rx_busy_q <= 1'b0;
            rx_push   <= 1'b0;
            rx_push_d <= '0;
        end else begin
            rx_push <= 1'b0;
            if (rx_st != RX_IDLE && tick) begin
                rx_scnt <= bit_end ? '0 : rx_scnt + OSW'(1);
                if (rx_scnt == SMP_LO)  v0 <= s2;
                if (rx_scnt == SMP_MID) v1 <= s2;
            end
            unique case (rx_st)
                RX_IDLE: begin
                    if (fall) begin
                        rx_st     <= RX_START;
                        rx_scnt   <= '0;
                        rx_busy_q <= 1'b1;
                        rx_perr   <= 1'b0;
                        rx_mode   <= parity_mode;
                    end
                end
                RX_START: begin
                    if (smp_hi && maj) begin
                        rx_st     <= RX_IDLE;
                        rx_busy_q <= 1'b0;
                    end else if (bit_end) begin
                        rx_st  <= RX_DATA;
                        rx_bit <= '0;
                    end
                end
                RX_DATA: begin
                    if (smp_hi) rx_sh <= {maj, rx_sh[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (rx_bit == BIT_LAST)
                            rx_st <= par_en(rx_mode) ? RX_PARITY : RX_STOP1;
                        else
                            rx_bit <= rx_bit + BW'(1);
                    end
                end
                RX_PARITY: begin
                    if (smp_hi)
                        rx_perr <= (parity_bit(rx_ext, rx_mode) != maj);
                    if (bit_end) rx_st <= RX_STOP1;
                end
                RX_STOP1: begin
                    // Finish mid stop bit so the next start edge is never missed.
                    if (smp_hi) begin
                        rx_push   <= 1'b1;
                        rx_push_d <= {~maj, rx_perr, rx_sh};
                        rx_st     <= RX_IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [FW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          ovr_q;

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_push_d),
        .pop   (io.rx_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) ovr_q <= 1'b0;
        else     ovr_q <= rx_push & fifo_full & ~io.rx_ready;
    end

    assign io.rx_data         = fifo_dout[DATA_BITS-1:0];
    assign io.rx_parity_error = fifo_dout[DATA_BITS];
    assign io.rx_frame_error  = fifo_dout[DATA_BITS+1];
    assign io.rx_data_valid   = ~fifo_empty;
    assign io.rx_level        = fifo_level;
    assign io.rx_overrun      = ovr_q;
    assign io.rx_busy         = rx_busy_q;
endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: scoreboard queue of expected
// RX entries, monitor pops on each FIFO handshake; directed + random frames.
module tb_uart_core_param;
    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] baud_div = '0;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic          sin_b = 1'b1;
    logic          loop = 1'b0;
    logic          sin_w;
    logic          sout;

    assign sin_w = loop ? sout : sin_b;

    uart_core_param_if #(.DATA_BITS(DB), .LW(LW)) io ();

    uart_core_param #(
        .DATA_BITS     (DB),
        .OVERSAMPLE    (OS),
        .DIV_WIDTH     (DW),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .sin         (sin_w),
        .sout        (sout),
        .io          (io)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;
    logic [DB+1:0] exp_q[$];
    logic [DB+1:0] mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every FIFO pop is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && io.rx_ready && io.rx_data_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected actual=%0h required=none",
                         {io.rx_frame_error, io.rx_parity_error, io.rx_data});
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_entry",
                    32'({io.rx_frame_error, io.rx_parity_error, io.rx_data}),
                    32'(mon_e));
            end
        end
        if (!rst && io.rx_overrun) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (!io.tx_ready && n < 3000) begin
            cyc();
            n++;
        end
        if (!io.tx_ready) begin
            total++;
            bad++;
            $display("FAIL tx_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic send(input logic [DB-1:0] d, input bit expect_rx);
        wait_tx_idle();
        io.tx_data = d;
        io.tx_data_valid = 1'b1;
        cyc();
        io.tx_data_valid = 1'b0;
        if (expect_rx) exp_q.push_back({2'b00, d});
    endtask

    // Bit-bang one frame on sin and queue the entry RX must report for it.
    task automatic drive_frame(input logic [DB-1:0] d, input int pm,
                               input bit flip, input bit stop);
        int   bp;
        logic p;
        logic fe;
        logic pe;
        bp = OS * (int'(baud_div) + 1);
        fe = ~stop;
        pe = flip && (pm == 1 || pm == 2);
        exp_q.push_back({fe, pe, d});
        sin_b = 1'b0;
        cyc(bp);
        for (int i = 0; i < DB; i++) begin
            sin_b = d[i];
            cyc(bp);
        end
        if (pm == 1 || pm == 2) begin
            p = ^d;
            if (pm == 2) p = ~p;
            sin_b = p ^ flip;
            cyc(bp);
        end
        sin_b = stop;
        cyc(bp);
        sin_b = 1'b1;
        cyc(2 * bp);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || io.rx_data_valid || io.rx_busy ||
                !io.tx_ready) && n < 5000) begin
            cyc();
            n++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic       sv[$];
        int         bc;
        int         s;
        int         run;
        int         idx;
        logic [9:0] fb;
        bit         seen;

        io.tx_data = '0;
        io.tx_data_valid = 1'b0;
        io.rx_ready = 1'b1;

        // reset state
        cyc(3);
        @(negedge clk);
        chk("rst_sout", 32'(sout), 32'd1);
        chk("rst_tx_ready", 32'(io.tx_ready), 32'd1);
        chk("rst_tx_busy", 32'(io.tx_busy), 32'd0);
        chk("rst_rx_busy", 32'(io.rx_busy), 32'd0);
        chk("rst_rx_valid", 32'(io.rx_data_valid), 32'd0);
        chk("rst_rx_level", 32'(io.rx_level), 32'd0);
        chk("rst_overrun", 32'(io.rx_overrun), 32'd0);
        chk("rst_perr", 32'(io.rx_parity_error), 32'd0);
        chk("rst_ferr", 32'(io.rx_frame_error), 32'd0);
        chk("rst_rx_data", 32'(io.rx_data), 32'd0);
        cyc();
        rst = 1'b0;
        cyc(2);

        // 8N1 0xA5 waveform, baud_div=0 -> 16 clk per bit
        send(8'hA5, 1'b0);
        @(negedge clk);
        chk("accept_ready_drop", 32'(io.tx_ready), 32'd0);
        chk("accept_busy_rise", 32'(io.tx_busy), 32'd1);
        bc = 0;
        while (io.tx_busy && bc < 1000) begin
            sv.push_back(sout);
            bc++;
            @(negedge clk);
        end
        // one cycle of accept latency precedes the 160-clk frame
        chk("tx_busy_len_ok", 32'(bc >= 160 && bc <= 161), 32'd1);
        s = 0;
        while (s < sv.size() && sv[s] != 1'b0) s++;
        run = 0;
        while (s + run < sv.size() && sv[s + run] == 1'b0) run++;
        chk("tx_start_len", 32'(run), 32'd16);
        fb = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            idx = s + 8 + 16 * k;
            if (idx < sv.size())
                chk($sformatf("tx_bit%0d", k), 32'(sv[idx]), 32'(fb[k]));
            else
                chk($sformatf("tx_bit%0d_present", k), 32'(sv.size()),
                    32'(idx + 1));
        end
        cyc(2);

        // loopback, even parity, two stop bits
        loop = 1'b1;
        parity_mode = 2'b01;
        two_stop = 1'b1;
        send(8'h3C, 1'b1);
        send(8'h81, 1'b1);
        wait_drain("drain_even");

        // odd parity with one corrupted parity bit
        loop = 1'b0;
        parity_mode = 2'b10;
        two_stop = 1'b0;
        drive_frame(8'h5A, 2, 1'b0, 1'b1);
        drive_frame(8'hC3, 2, 1'b1, 1'b1);
        drive_frame(8'h0F, 2, 1'b0, 1'b1);
        wait_drain("drain_odd");

        // framing error, then a clean frame
        parity_mode = 2'b00;
        drive_frame(8'h55, 0, 1'b0, 1'b0);
        drive_frame(8'hA0, 0, 1'b0, 1'b1);
        wait_drain("drain_frame");

        // overrun: DEPTH+1 frames with no pops
        loop = 1'b1;
        io.rx_ready = 1'b0;
        ovr_cnt = 0;
        for (int i = 0; i < DEPTH + 1; i++)
            send(DB'($urandom), i < DEPTH);
        wait_tx_idle();
        cyc(60);
        chk("ovr_level", 32'(io.rx_level), 32'(DEPTH));
        chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
        chk("ovr_valid", 32'(io.rx_data_valid), 32'd1);
        io.rx_ready = 1'b1;
        wait_drain("drain_ovr");

        // random loopback frames and configurations
        for (int i = 0; i < 10; i++) begin
            wait_tx_idle();
            cyc(4);
            baud_div = DW'($urandom_range(0, 2));
            parity_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
            io.rx_ready = (i % 4 == 3) || ($urandom_range(0, 3) != 0);
            send(DB'($urandom), 1'b1);
        end
        io.rx_ready = 1'b1;
        wait_drain("drain_rand");
        chk("rand_ovr_none", 32'(ovr_cnt), 32'd1);

        // start-bit glitch of 4 ticks
        wait_tx_idle();
        cyc(4);
        baud_div = '0;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        loop = 1'b0;
        cyc(4);
        sin_b = 1'b0;
        cyc(4);
        sin_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (io.rx_busy) seen = 1'b1;
        end
        chk("glitch_busy_seen", 32'(seen), 32'd1);
        chk("glitch_busy_end", 32'(io.rx_busy), 32'd0);
        chk("glitch_no_push", 32'(io.rx_level), 32'd0);

        // reset mid-TX frame also flushes the FIFO
        io.rx_ready = 1'b0;
        drive_frame(8'h6B, 0, 1'b0, 1'b1);
        void'(exp_q.pop_back());
        chk("pre_rst_level", 32'(io.rx_level), 32'd1);
        send(8'h00, 1'b0);
        cyc(50);
        @(negedge clk);
        chk("mid_tx_sout", 32'(sout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_sout", 32'(sout), 32'd1);
        chk("rst_mid_busy", 32'(io.tx_busy), 32'd0);
        chk("rst_mid_ready", 32'(io.tx_ready), 32'd1);
        chk("rst_flush_level", 32'(io.rx_level), 32'd0);
        chk("rst_flush_valid", 32'(io.rx_data_valid), 32'd0);
        io.rx_ready = 1'b1;
        cyc(5);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
